// File: rtl/plen_meter_pkg.sv
// Shared constants and helpers for the packet length meter: record flag layout,
// statistics counter width and the tkeep popcount.
package plen_meter_pkg;

    localparam int ERR   = 0;
    localparam int RUNT  = 1;
    localparam int GIANT = 2;
    localparam int SAT   = 3;

    localparam int TUSER_W    = 4;
    localparam int PLEN_W_DEF = 16;
    localparam int REC_W      = PLEN_W_DEF + TUSER_W;
    localparam int STAT_W     = 32;

    // Widest tkeep the popcount helper accepts; narrower buses are zero-extended.
    localparam int KEEP_MAX = 256;

    function automatic int unsigned popcount(input logic [KEEP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/plen_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is always visible on
// o_rd_data straight from storage while o_empty is low.
module plen_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    // The extra pointer bit separates a full ring from an empty one.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_wr = i_wr_en && !o_full;
    assign w_rd = i_rd_en && !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/plen_meter.sv
// AXI-Stream sink that measures per-packet byte length from tkeep, classifies
// the packet, queues one record per packet and keeps saturating statistics.
module plen_meter
    import plen_meter_pkg::*;
#(
    parameter int DW           = 512,
    parameter int PLEN_W       = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int MIN_LEN      = 64,
    parameter int MAX_LEN      = 9600,
    parameter int BACKPRESSURE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DW-1:0]       axis_in_tdata,
    input  logic [DW/8-1:0]     axis_in_tkeep,
    input  logic                axis_in_tlast,
    input  logic                axis_in_tuser,
    input  logic                axis_in_tvalid,
    output logic                axis_in_tready,
    output logic [PLEN_W-1:0]   plen_tdata,
    output logic [TUSER_W-1:0]  plen_tuser,
    output logic                plen_tvalid,
    input  logic                plen_tready,
    input  logic                clear_stats,
    output logic [STAT_W-1:0]   pkt_count,
    output logic [STAT_W-1:0]   err_count,
    output logic [STAT_W-1:0]   drop_count
);

    localparam int KW    = DW / 8;
    localparam int CNT_W = $clog2(KW + 1);
    localparam int RW    = PLEN_W + TUSER_W;
    localparam logic [STAT_W-1:0] MIN_L = STAT_W'(MIN_LEN);
    localparam logic [STAT_W-1:0] MAX_L = STAT_W'(MAX_LEN);

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
        return (&c) ? c : c + STAT_W'(1);
    endfunction

    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_clamp;
    logic [CNT_W-1:0]   w_bytes;
    logic [PLEN_W:0]    w_sum;
    logic [PLEN_W-1:0]  w_len;
    logic [TUSER_W-1:0] w_flags;
    logic [RW-1:0]      w_rec;
    logic [RW-1:0]      w_head;
    logic [PLEN_W-1:0]  r_acc;
    logic               r_sat;
    logic               r_err;
    logic               w_unused_tdata;

    assign w_unused_tdata = ^axis_in_tdata;

    assign axis_in_tready = !reset && ((BACKPRESSURE == 0) || !w_full);
    assign w_accept       = axis_in_tvalid && axis_in_tready;
    assign w_push         = w_accept && axis_in_tlast;
    assign w_pop          = plen_tvalid && plen_tready;
    // Fullness is taken before this cycle's pop, so a simultaneous pop cannot rescue the record.
    assign w_drop         = (BACKPRESSURE == 0) && w_push && w_full;

    assign w_bytes = CNT_W'(popcount(KEEP_MAX'(axis_in_tkeep)));
    assign w_sum   = {1'b0, r_acc} + (PLEN_W+1)'(w_bytes);
    assign w_clamp = w_sum[PLEN_W];
    assign w_len   = w_clamp ? '1 : w_sum[PLEN_W-1:0];

    always_comb begin
        w_flags        = '0;
        w_flags[ERR]   = r_err | axis_in_tuser;
        w_flags[RUNT]  = STAT_W'(w_len) < MIN_L;
        w_flags[GIANT] = STAT_W'(w_len) > MAX_L;
        w_flags[SAT]   = r_sat | w_clamp;
    end

    assign w_rec = {w_flags, w_len};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_sat <= 1'b0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            if (axis_in_tlast) begin
                r_acc <= '0;
                r_sat <= 1'b0;
                r_err <= 1'b0;
            end else begin
                r_acc <= w_len;
                r_sat <= r_sat | w_clamp;
                r_err <= r_err | axis_in_tuser;
            end
        end
    end

    plen_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_data (w_rec),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign plen_tvalid              = !w_empty;
    assign {plen_tuser, plen_tdata} = w_head;

    // A clear in the same cycle as an event wins; that event is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count  <= '0;
            err_count  <= '0;
            drop_count <= '0;
        end else if (clear_stats) begin
            pkt_count  <= '0;
            err_count  <= '0;
            drop_count <= '0;
        end else begin
            if (w_push)                 pkt_count  <= sat_inc(pkt_count);
            if (w_push && w_flags[ERR]) err_count  <= sat_inc(err_count);
            if (w_drop)                 drop_count <= sat_inc(drop_count);
        end
    end

endmodule

// File: tb/tb_plen_meter.sv
// Directed bench for plen_meter: three instances cover the default build, a
// narrow PLEN_W=10 build and a BACKPRESSURE=0 build.
module tb_plen_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         clear_stats;
    logic [511:0] tdata_z = '0;

    logic [63:0] keep_a, keep_b, keep_c;
    logic        last_a, last_b, last_c;
    logic        user_a, user_b, user_c;
    logic        valid_a, valid_b, valid_c;
    logic        tready_a, tready_b, tready_c;
    logic [15:0] tdata_a, tdata_c;
    logic [9:0]  tdata_b;
    logic [3:0]  tuser_a, tuser_b, tuser_c;
    logic        tvalid_a, tvalid_b, tvalid_c;
    logic        ready_a, ready_b, ready_c;
    logic [31:0] pkt_a, err_a, drop_a;
    logic [31:0] pkt_b, err_b, drop_b;
    logic [31:0] pkt_c, err_c, drop_c;

    int pass_cnt = 0;
    int total    = 0;

    plen_meter u_dut_a (
        .clk(clk), .reset(reset), .axis_in_tdata(tdata_z), .axis_in_tkeep(keep_a),
        .axis_in_tlast(last_a), .axis_in_tuser(user_a), .axis_in_tvalid(valid_a),
        .axis_in_tready(tready_a), .plen_tdata(tdata_a), .plen_tuser(tuser_a),
        .plen_tvalid(tvalid_a), .plen_tready(ready_a), .clear_stats(clear_stats),
        .pkt_count(pkt_a), .err_count(err_a), .drop_count(drop_a)
    );

    plen_meter #(.PLEN_W(10)) u_dut_b (
        .clk(clk), .reset(reset), .axis_in_tdata(tdata_z), .axis_in_tkeep(keep_b),
        .axis_in_tlast(last_b), .axis_in_tuser(user_b), .axis_in_tvalid(valid_b),
        .axis_in_tready(tready_b), .plen_tdata(tdata_b), .plen_tuser(tuser_b),
        .plen_tvalid(tvalid_b), .plen_tready(ready_b), .clear_stats(clear_stats),
        .pkt_count(pkt_b), .err_count(err_b), .drop_count(drop_b)
    );

    plen_meter #(.BACKPRESSURE(0)) u_dut_c (
        .clk(clk), .reset(reset), .axis_in_tdata(tdata_z), .axis_in_tkeep(keep_c),
        .axis_in_tlast(last_c), .axis_in_tuser(user_c), .axis_in_tvalid(valid_c),
        .axis_in_tready(tready_c), .plen_tdata(tdata_c), .plen_tuser(tuser_c),
        .plen_tvalid(tvalid_c), .plen_tready(ready_c), .clear_stats(clear_stats),
        .pkt_count(pkt_c), .err_count(err_c), .drop_count(drop_c)
    );

    function automatic logic [63:0] mask(input int n);
        logic [63:0] m;
        m = '1;
        if (n == 0) return '0;
        return m >> (64 - n);
    endfunction

    function automatic logic rdy(input int d);
        case (d)
            0:       return tready_a;
            1:       return tready_b;
            default: return tready_c;
        endcase
    endfunction

    task automatic drive(input int d, input logic [63:0] k, input logic l, input logic u, input logic v);
        case (d)
            0:       begin keep_a = k; last_a = l; user_a = u; valid_a = v; end
            1:       begin keep_b = k; last_b = l; user_b = u; valid_b = v; end
            default: begin keep_c = k; last_c = l; user_c = u; valid_c = v; end
        endcase
    endtask

    task automatic beat(input int d, input logic [63:0] k, input logic l, input logic u);
        int n;
        drive(d, k, l, u, 1'b1);
        n = 0;
        while (!rdy(d) && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy(d)) begin
            total++;
            $display("FAIL beat_timeout inst=%0d tready=0 required=1", d);
        end else begin
            @(posedge clk); #1;
        end
        drive(d, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_pkt(input int d, input int nfull, input logic [63:0] lk, input int ub);
        for (int i = 0; i < nfull; i++) beat(d, '1, 1'b0, i == ub);
        beat(d, lk, 1'b1, nfull == ub);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clear_stats = 1'b0;
        ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total++; if (tready_a !== 1'b0) $display("FAIL rst_tready got=%b exp=0", tready_a); else pass_cnt++;
        total++; if (tvalid_a !== 1'b0) $display("FAIL rst_tvalid got=%b exp=0", tvalid_a); else pass_cnt++;
        total++; if (pkt_a !== 32'd0) $display("FAIL rst_pkt got=%0d exp=0", pkt_a); else pass_cnt++;
        total++; if (err_a !== 32'd0) $display("FAIL rst_err got=%0d exp=0", err_a); else pass_cnt++;
        total++; if (drop_c !== 32'd0) $display("FAIL rst_drop got=%0d exp=0", drop_c); else pass_cnt++;
        total++; if (tready_c !== 1'b0) $display("FAIL rst_tready_c got=%b exp=0", tready_c); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (tready_a !== 1'b1) $display("FAIL post_rst_tready got=%b exp=1", tready_a); else pass_cnt++;
    endtask

    task automatic test_basic;
        send_pkt(0, 2, 64'h000F, -1);
        total++; if (tvalid_a !== 1'b1) $display("FAIL basic_valid got=%b exp=1", tvalid_a); else pass_cnt++;
        total++; if (tdata_a !== 16'd132) $display("FAIL basic_len got=%0d exp=132", tdata_a); else pass_cnt++;
        total++; if (tuser_a !== 4'b0000) $display("FAIL basic_tuser got=%b exp=0000", tuser_a); else pass_cnt++;
        total++; if (pkt_a !== 32'd1) $display("FAIL basic_pkt got=%0d exp=1", pkt_a); else pass_cnt++;
        @(posedge clk); #1;
        total++; if (tvalid_a !== 1'b0) $display("FAIL basic_popped got=%b exp=0", tvalid_a); else pass_cnt++;
    endtask

    task automatic test_classify;
        beat(0, 64'h0000_00FF_FFFF_FFFF, 1'b1, 1'b1);
        total++; if (tdata_a !== 16'd40) $display("FAIL runt_len got=%0d exp=40", tdata_a); else pass_cnt++;
        total++; if (tuser_a !== 4'b0011) $display("FAIL runt_tuser got=%b exp=0011", tuser_a); else pass_cnt++;
        total++; if (err_a !== 32'd1) $display("FAIL runt_errcnt got=%0d exp=1", err_a); else pass_cnt++;
        send_pkt(0, 151, '1, -1);
        total++; if (tdata_a !== 16'd9728) $display("FAIL giant_len got=%0d exp=9728", tdata_a); else pass_cnt++;
        total++; if (tuser_a !== 4'b0100) $display("FAIL giant_tuser got=%b exp=0100", tuser_a); else pass_cnt++;
        total++; if (err_a !== 32'd1) $display("FAIL giant_errcnt got=%0d exp=1", err_a); else pass_cnt++;
        total++; if (pkt_a !== 32'd3) $display("FAIL giant_pkt got=%0d exp=3", pkt_a); else pass_cnt++;
        send_pkt(0, 149, '1, 2);
        total++; if (tdata_a !== 16'd9600) $display("FAIL maxlen_len got=%0d exp=9600", tdata_a); else pass_cnt++;
        total++; if (tuser_a !== 4'b0001) $display("FAIL maxlen_tuser got=%b exp=0001", tuser_a); else pass_cnt++;
        total++; if (err_a !== 32'd2) $display("FAIL maxlen_errcnt got=%0d exp=2", err_a); else pass_cnt++;
        beat(0, {32{2'b10}}, 1'b0, 1'b0);
        beat(0, 64'h0, 1'b0, 1'b0);
        beat(0, 64'h8000_0000_0000_0001, 1'b1, 1'b0);
        total++; if (tdata_a !== 16'd34) $display("FAIL sparse_len got=%0d exp=34", tdata_a); else pass_cnt++;
        total++; if (tuser_a !== 4'b0010) $display("FAIL sparse_tuser got=%b exp=0010", tuser_a); else pass_cnt++;
        beat(0, '1, 1'b1, 1'b0);
        total++; if (tdata_a !== 16'd64) $display("FAIL minlen_len got=%0d exp=64", tdata_a); else pass_cnt++;
        total++; if (tuser_a !== 4'b0000) $display("FAIL minlen_tuser got=%b exp=0000", tuser_a); else pass_cnt++;
        total++; if (pkt_a !== 32'd6) $display("FAIL classify_pkt got=%0d exp=6", pkt_a); else pass_cnt++;
    endtask

    task automatic test_saturate;
        send_pkt(1, 17, 64'h0FFF, -1);
        total++; if (tdata_b !== 10'd1023) $display("FAIL sat_len got=%0d exp=1023", tdata_b); else pass_cnt++;
        total++; if (tuser_b !== 4'b1000) $display("FAIL sat_tuser got=%b exp=1000", tuser_b); else pass_cnt++;
        beat(1, '1, 1'b1, 1'b0);
        total++; if (tdata_b !== 10'd64) $display("FAIL sat_next_len got=%0d exp=64", tdata_b); else pass_cnt++;
        total++; if (tuser_b !== 4'b0000) $display("FAIL sat_next_tuser got=%b exp=0000", tuser_b); else pass_cnt++;
        total++; if (pkt_b !== 32'd2 || err_b !== 32'd0 || drop_b !== 32'd0)
            $display("FAIL sat_counts got=%0d/%0d/%0d exp=2/0/0", pkt_b, err_b, drop_b); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int idx;
        ready_a = 1'b0;
        for (int i = 0; i < 8; i++) beat(0, mask(56 + i), 1'b1, 1'b0);
        total++; if (tready_a !== 1'b0) $display("FAIL bp_full_tready got=%b exp=0", tready_a); else pass_cnt++;
        total++; if (tvalid_a !== 1'b1 || tdata_a !== 16'd56)
            $display("FAIL bp_head got=%b/%0d exp=1/56", tvalid_a, tdata_a); else pass_cnt++;
        drive(0, '1, 1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        total++; if (pkt_a !== 32'd14) $display("FAIL bp_stall_pkt got=%0d exp=14", pkt_a); else pass_cnt++;
        total++; if (tdata_a !== 16'd56) $display("FAIL bp_hold got=%0d exp=56", tdata_a); else pass_cnt++;
        ready_a = 1'b1;
        idx = 0;
        fork
            beat(0, '1, 1'b1, 1'b0);
            begin
                for (int n = 0; n < 40 && idx < 9; n++) begin
                    @(negedge clk);
                    if (tvalid_a) begin
                        total++;
                        if (tdata_a !== 16'(56 + idx) || tuser_a !== ((idx < 8) ? 4'b0010 : 4'b0000))
                            $display("FAIL bp_drain[%0d] got=%0d/%b exp=%0d", idx, tdata_a, tuser_a, 56 + idx);
                        else pass_cnt++;
                        idx++;
                    end
                end
            end
        join
        total++; if (idx !== 9) $display("FAIL bp_drain_count got=%0d exp=9", idx); else pass_cnt++;
        @(posedge clk); #1;
        total++; if (drop_a !== 32'd0 || pkt_a !== 32'd15)
            $display("FAIL bp_counts got=drop %0d pkt %0d exp=drop 0 pkt 15", drop_a, pkt_a); else pass_cnt++;
    endtask

    task automatic test_no_backpressure;
        int idx;
        ready_c = 1'b0;
        for (int i = 0; i < 9; i++) beat(2, mask(56 + i), 1'b1, 1'b0);
        total++; if (tready_c !== 1'b1) $display("FAIL nobp_tready got=%b exp=1", tready_c); else pass_cnt++;
        total++; if (drop_c !== 32'd1) $display("FAIL nobp_drop got=%0d exp=1", drop_c); else pass_cnt++;
        total++; if (pkt_c !== 32'd9) $display("FAIL nobp_pkt got=%0d exp=9", pkt_c); else pass_cnt++;
        ready_c = 1'b1;
        idx = 0;
        for (int n = 0; n < 20 && idx < 8; n++) begin
            @(negedge clk);
            if (tvalid_c) begin
                total++;
                if (tdata_c !== 16'(56 + idx)) $display("FAIL nobp_drain[%0d] got=%0d exp=%0d", idx, tdata_c, 56 + idx);
                else pass_cnt++;
                idx++;
            end
        end
        @(posedge clk); #1;
        total++; if (idx !== 8 || tvalid_c !== 1'b0)
            $display("FAIL nobp_kept got=%0d valid=%b exp=8 valid=0", idx, tvalid_c); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        ready_a = 1'b1;
        beat(0, '1, 1'b0, 1'b0);
        beat(0, '1, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        total++; if (tready_a !== 1'b0 || pkt_a !== 32'd0)
            $display("FAIL midrst_state got=tready %b pkt %0d exp=0/0", tready_a, pkt_a); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (tvalid_a !== 1'b0) $display("FAIL midrst_no_record got=%b exp=0", tvalid_a); else pass_cnt++;
        beat(0, mask(20), 1'b1, 1'b0);
        total++; if (tdata_a !== 16'd20 || tuser_a !== 4'b0010)
            $display("FAIL midrst_fresh got=%0d/%b exp=20/0010", tdata_a, tuser_a); else pass_cnt++;
        total++; if (pkt_a !== 32'd1) $display("FAIL midrst_pkt got=%0d exp=1", pkt_a); else pass_cnt++;
        clear_stats = 1'b1;
        beat(0, '1, 1'b1, 1'b1);
        clear_stats = 1'b0;
        total++; if (pkt_a !== 32'd0 || err_a !== 32'd0 || drop_a !== 32'd0)
            $display("FAIL clear_counts got=%0d/%0d/%0d exp=0/0/0", pkt_a, err_a, drop_a); else pass_cnt++;
        total++; if (tvalid_a !== 1'b1 || tdata_a !== 16'd64 || tuser_a !== 4'b0001)
            $display("FAIL clear_record got=%b/%0d/%b exp=1/64/0001", tvalid_a, tdata_a, tuser_a); else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_classify();
        test_saturate();
        test_back_to_back();
        test_no_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/plen_meter.md
Name: plen_meter

Overview:
- Sink-only AXI-Stream monitor. Measures the byte length of every packet on a DW-bit stream by counting tkeep ones per beat.
- Classifies each packet as errored, runt, giant or saturated.
- Queues one result per packet in a FIFO with its own valid/ready handshake, and keeps saturating statistics counters.
- Sits beside the packet datapath in the packet-count design and feeds per-packet length records to downstream logic.

Parameters:
- DW, 512, input data width in bits; multiple of 8; DW/8 ≤ 2^PLEN_W-1.
- PLEN_W, 16, width of the reported packet length.
- FIFO_DEPTH, 8, number of result entries; power of 2, ≥ 2.
- MIN_LEN, 64, packets shorter than this are runts.
- MAX_LEN, 9600, packets longer than this are giants.
- BACKPRESSURE, 1: 1 = stall the input when the FIFO is full; 0 = input always ready, results dropped when full.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- axis_in_tdata  in  DW  ignored (present for bus compatibility).
- axis_in_tkeep  in  DW/8  byte enables; need not be contiguous.
- axis_in_tlast  in  1  last beat of packet.
- axis_in_tuser  in  1  packet-corrupt flag; sampled on any beat.
- axis_in_tvalid  in  1  input beat valid.
- axis_in_tready  out  1  input ready.
- plen_tdata  out  PLEN_W  packet length in bytes.
- plen_tuser  out  4  {sat, giant, runt, err}; bit indices are defined in the package.
- plen_tvalid  out  1  result valid.
- plen_tready  in  1  result accepted.
- clear_stats  in  1  synchronous one-cycle pulse; zeroes the counters.
- pkt_count  out  32  packets completed, including dropped ones.
- err_count  out  32  packets with err set.
- drop_count  out  32  results lost to a full FIFO (BACKPRESSURE=0 only).

Behaviour:
- Reset (asynchronous assert; release is synchronous to clk by the integrator):
  - accumulator, error latch, FIFO pointers and all counters go to 0;
  - plen_tvalid = 0, axis_in_tready = 0.
- axis_in_tready:
  - BACKPRESSURE=1: !reset && !fifo_full;
  - BACKPRESSURE=0: !reset.
  - It is evaluated on every beat, not only on tlast.
- Beat accepted = tvalid & tready.
- bytes_in_beat = popcount(tkeep), combinational, width clog2(DW/8+1).
- Accumulation on each accepted non-last beat:
  - acc <= min(acc + bytes_in_beat, 2^PLEN_W-1);
  - sat_latch is set if clamping occurred;
  - err_latch |= tuser.
- Accepted last beat:
  - len = min(acc + bytes_in_beat, 2^PLEN_W-1);
  - sat = sat_latch | clamp;
  - err = err_latch | tuser;
  - runt = len < MIN_LEN;
  - giant = len > MAX_LEN, using the clamped length;
  - the record is pushed to the FIFO;
  - acc, sat_latch and err_latch clear at the same edge.
- A single-beat packet (tlast on its first beat) is legal. A zero-byte beat (tkeep = 0) is legal and contributes 0.
- Latency: a record pushed at edge N appears on plen_tdata/plen_tvalid after edge N (first-word-fall-through). Output is registered from FIFO storage.
- FIFO: FIFO_DEPTH entries of PLEN_W+4 bits.
  - Pop when plen_tvalid & plen_tready.
  - Push and pop in the same cycle are both honoured.
  - Full and empty are tracked with an extra pointer bit; pointers wrap modulo FIFO_DEPTH.
- Output hold: plen_tdata/plen_tuser stay stable while plen_tvalid=1 and plen_tready=0.
- Drop (BACKPRESSURE=0 only): if a record is pushed while the FIFO is full, it is discarded and drop_count increments.
  - Fullness is sampled before that cycle's pop, so a pop in the same cycle does not save the record.
- Counters (saturate at 2^32-1, no wrap):
  - pkt_count increments on every accepted last beat;
  - err_count increments when err=1;
  - drop_count as above.
- clear_stats:
  - zeroes all three counters at the next edge;
  - if a clear and an increment fall in the same cycle, the clear wins and the increment is lost;
  - it does not affect the FIFO or the accumulator.
- Reset mid-packet: the partial packet is discarded and no record is produced. After release, the next beat starts a new packet.

Decomposition:
- plen_meter_pkg contains:
  - tuser bit index constants: ERR=0, RUNT=1, GIANT=2, SAT=3;
  - the record width constant REC_W = PLEN_W+4;
  - the 32-bit counter width constant;
  - a popcount function.
- Sub-module plen_fifo: a parametrised synchronous FWFT FIFO (WIDTH, DEPTH) with full/empty flags and asynchronous active-high reset.
- plen_meter contains the accumulator, classification and counters.

Test Plan:
- DW=512, packet of 3 beats with all tkeep ones, last tkeep=0x000F, plen_tready=1 -> one record, plen_tdata=132, tuser=0, pkt_count=1.
- 40-byte single beat with tuser=1 on that beat; then a 9728-byte packet -> records (40, {runt,err}) and (9728, {giant}); err_count=1.
- PLEN_W=10, packet of 1100 bytes -> plen_tdata=1023, sat=1, giant per MAX_LEN.
- BACKPRESSURE=1, plen_tready=0, 9 single-beat packets -> 8 records queued, tready=0 after the 8th. Raising plen_tready drains the records in order and the 9th is then accepted; drop_count=0.
- BACKPRESSURE=0, same stimulus -> tready stays 1, 8 records kept, drop_count=1, pkt_count=9.
- Reset asserted in mid-packet, then clear_stats coinciding with a packet's last beat -> no partial record is produced, and all counters read 0 the cycle after the clear.
